// File: rtl/ysyx_22050710_axi4_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22050710_axi4_rd_arbiter
// Purpose  : 2:1 AXI4 read-channel arbiter. M0 (IFU) and M1 (LSU) share one
//            AXI4 read port towards the SRAM slave. Only one read is in
//            flight at a time. Simultaneous requests are resolved round-robin.
// Ports    : i_aclk / i_arsetn      - clock, synchronous active-low reset
//            i_mN_ar* / o_mN_arready - per-master AR request channel
//            o_mN_r* / i_mN_rready   - per-master R response channel
//            o_ar* / i_arready       - slave AR channel (registered fields)
//            i_r* / o_rready         - slave R channel (i_rid unused)
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22050710_axi4_rd_arbiter #(
  parameter int SRAM_ADDR_WD = 64,
  parameter int SRAM_DATA_WD = 64
) (
  input  logic                    i_aclk,
  input  logic                    i_arsetn,

  // Master 0 (IFU)
  input  logic                    i_m0_arvalid,
  output logic                    o_m0_arready,
  input  logic [SRAM_ADDR_WD-1:0] i_m0_araddr,
  input  logic [7:0]              i_m0_arlen,
  input  logic [2:0]              i_m0_arsize,
  output logic                    o_m0_rvalid,
  input  logic                    i_m0_rready,
  output logic [SRAM_DATA_WD-1:0] o_m0_rdata,
  output logic [1:0]              o_m0_rresp,
  output logic                    o_m0_rlast,

  // Master 1 (LSU)
  input  logic                    i_m1_arvalid,
  output logic                    o_m1_arready,
  input  logic [SRAM_ADDR_WD-1:0] i_m1_araddr,
  input  logic [7:0]              i_m1_arlen,
  input  logic [2:0]              i_m1_arsize,
  output logic                    o_m1_rvalid,
  input  logic                    i_m1_rready,
  output logic [SRAM_DATA_WD-1:0] o_m1_rdata,
  output logic [1:0]              o_m1_rresp,
  output logic                    o_m1_rlast,

  // Slave AR channel
  output logic [3:0]              o_arid,
  output logic [SRAM_ADDR_WD-1:0] o_araddr,
  output logic [7:0]              o_arlen,
  output logic [2:0]              o_arsize,
  output logic [1:0]              o_arburst,
  output logic                    o_arvalid,
  input  logic                    i_arready,

  // Slave R channel
  input  logic [3:0]              i_rid,
  input  logic [SRAM_DATA_WD-1:0] i_rdata,
  input  logic [1:0]              i_rresp,
  input  logic                    i_rlast,
  input  logic                    i_rvalid,
  output logic                    o_rready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                  state;
  logic                    grant;       // 0 = M0, 1 = M1
  logic                    last_grant;  // master served by the last completed read
  logic [SRAM_ADDR_WD-1:0] addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;

  logic pick;
  logic accept;
  logic in_data;
  logic grant_rready;
  logic last_beat;

  // Routing is by the grant register alone; the returned ID carries nothing
  // we need.
  logic unused_rid;
  assign unused_rid = ^i_rid;

  always_comb begin
    // On a tie, serve whichever master did not win last time.
    pick         = (i_m0_arvalid & i_m1_arvalid) ? ~last_grant : i_m1_arvalid;
    // Outputs are gated by reset so handshakes are quiet during reset even
    // before the first clock edge has forced the state.
    accept       = i_arsetn & (state == ST_IDLE) & (i_m0_arvalid | i_m1_arvalid);
    in_data      = i_arsetn & (state == ST_DATA);
    grant_rready = grant ? i_m1_rready : i_m0_rready;
    last_beat    = i_rvalid & o_rready & i_rlast;
  end

  assign o_m0_arready = accept & ~pick;
  assign o_m1_arready = accept &  pick;

  assign o_arid    = {3'b000, grant};
  assign o_araddr  = addr_q;
  assign o_arlen   = len_q;
  assign o_arsize  = size_q;
  assign o_arburst = 2'b01;
  assign o_arvalid = i_arsetn & (state == ST_ADDR);

  assign o_rready  = in_data & grant_rready;

  // The master not being served sees an all-zero R channel.
  assign o_m0_rvalid = in_data & ~grant & i_rvalid;
  assign o_m0_rdata  = (in_data & ~grant) ? i_rdata : '0;
  assign o_m0_rresp  = (in_data & ~grant) ? i_rresp : 2'b00;
  assign o_m0_rlast  = in_data & ~grant & i_rlast;

  assign o_m1_rvalid = in_data & grant & i_rvalid;
  assign o_m1_rdata  = (in_data & grant) ? i_rdata : '0;
  assign o_m1_rresp  = (in_data & grant) ? i_rresp : 2'b00;
  assign o_m1_rlast  = in_data & grant & i_rlast;

  always_ff @(posedge i_aclk) begin
    if (!i_arsetn) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b0;
      addr_q     <= '0;
      len_q      <= 8'd0;
      size_q     <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            grant  <= pick;
            addr_q <= pick ? i_m1_araddr : i_m0_araddr;
            len_q  <= pick ? i_m1_arlen  : i_m0_arlen;
            size_q <= pick ? i_m1_arsize : i_m0_arsize;
            state  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (i_arready) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (last_beat) begin
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050710_axi4_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22050710_axi4_rd_arbiter
// Purpose  : Self-checking bench for the 2:1 AXI4 read arbiter. A simple
//            SRAM-slave stand-in produces beats; a transaction-level model
//            (round-robin winner, expected AR fields, expected beat stream)
//            supplies every expected value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22050710_axi4_rd_arbiter;

  logic        clk;
  logic        arsetn;
  logic        m0_arvalid, m1_arvalid;
  logic        m0_arready, m1_arready;
  logic [63:0] m0_araddr, m1_araddr;
  logic [7:0]  m0_arlen, m1_arlen;
  logic [2:0]  m0_arsize, m1_arsize;
  logic        m0_rvalid, m1_rvalid;
  logic        m0_rready, m1_rready;
  logic [63:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic        m0_rlast, m1_rlast;
  logic [3:0]  arid;
  logic [63:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int total = 0;
  int bad   = 0;
  bit model_last = 1'b0;  // master that completed the previous read

  ysyx_22050710_axi4_rd_arbiter #(
    .SRAM_ADDR_WD(64),
    .SRAM_DATA_WD(64)
  ) dut (
    .i_aclk      (clk),
    .i_arsetn    (arsetn),
    .i_m0_arvalid(m0_arvalid),
    .o_m0_arready(m0_arready),
    .i_m0_araddr (m0_araddr),
    .i_m0_arlen  (m0_arlen),
    .i_m0_arsize (m0_arsize),
    .o_m0_rvalid (m0_rvalid),
    .i_m0_rready (m0_rready),
    .o_m0_rdata  (m0_rdata),
    .o_m0_rresp  (m0_rresp),
    .o_m0_rlast  (m0_rlast),
    .i_m1_arvalid(m1_arvalid),
    .o_m1_arready(m1_arready),
    .i_m1_araddr (m1_araddr),
    .i_m1_arlen  (m1_arlen),
    .i_m1_arsize (m1_arsize),
    .o_m1_rvalid (m1_rvalid),
    .i_m1_rready (m1_rready),
    .o_m1_rdata  (m1_rdata),
    .o_m1_rresp  (m1_rresp),
    .o_m1_rlast  (m1_rlast),
    .o_arid      (arid),
    .o_araddr    (araddr),
    .o_arlen     (arlen),
    .o_arsize    (arsize),
    .o_arburst   (arburst),
    .o_arvalid   (arvalid),
    .i_arready   (arready),
    .i_rid       (rid),
    .i_rdata     (rdata),
    .i_rresp     (rresp),
    .i_rlast     (rlast),
    .i_rvalid    (rvalid),
    .o_rready    (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_arvalid"},   {63'd0, arvalid},    64'd0);
    chk({tag, "_rready"},    {63'd0, rready},     64'd0);
    chk({tag, "_m0_arready"},{63'd0, m0_arready}, 64'd0);
    chk({tag, "_m1_arready"},{63'd0, m1_arready}, 64'd0);
    chk({tag, "_m0_rvalid"}, {63'd0, m0_rvalid},  64'd0);
    chk({tag, "_m1_rvalid"}, {63'd0, m1_rvalid},  64'd0);
  endtask

  // One complete read, starting in an idle cycle just after a clock edge.
  // mode: 0 = master always ready, 1 = random rready, 2 = toggling rready.
  task automatic run_txn(input bit r0, input bit r1,
                         input logic [63:0] a0, input logic [63:0] a1,
                         input logic [7:0] l0, input logic [7:0] l1,
                         input logic [2:0] s0, input logic [2:0] s1,
                         input int arwait, input int mode,
                         input logic [63:0] d0);
    bit          g;
    bit          rr;
    logic [63:0] ea;
    logic [7:0]  el;
    logic [2:0]  es;
    logic [63:0] d;
    logic [1:0]  rs;
    bit          lst;

    m0_arvalid = r0; m0_araddr = a0; m0_arlen = l0; m0_arsize = s0;
    m1_arvalid = r1; m1_araddr = a1; m1_arlen = l1; m1_arsize = s1;
    #1;
    g  = (r0 && r1) ? !model_last : r1;
    ea = g ? a1 : a0;
    el = g ? l1 : l0;
    es = g ? s1 : s0;
    chk("grant_m0_arready", {63'd0, m0_arready}, {63'd0, !g});
    chk("grant_m1_arready", {63'd0, m1_arready}, {63'd0, g});
    chk("idle_arvalid",     {63'd0, arvalid},    64'd0);
    tick();
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;

    // Address phase, optionally stalled by the slave; R-channel noise must
    // not leak through.
    for (int i = 0; i < arwait; i++) begin
      rvalid = 1'b1; rdata = {$urandom, $urandom}; rlast = 1'b1;
      #1;
      chk("addr_arvalid",   {63'd0, arvalid},    64'd1);
      chk("addr_araddr",    araddr,              ea);
      chk("addr_arid",      {60'd0, arid},       {63'd0, g});
      chk("addr_arlen",     {56'd0, arlen},      {56'd0, el});
      chk("addr_arsize",    {61'd0, arsize},     {61'd0, es});
      chk("addr_m0_arready",{63'd0, m0_arready}, 64'd0);
      chk("addr_m1_arready",{63'd0, m1_arready}, 64'd0);
      chk("addr_m0_rvalid", {63'd0, m0_rvalid},  64'd0);
      chk("addr_m1_rvalid", {63'd0, m1_rvalid},  64'd0);
      chk("addr_rready",    {63'd0, rready},     64'd0);
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0;
    arready = 1'b1;
    #1;
    chk("ar_arvalid", {63'd0, arvalid},  64'd1);
    chk("ar_araddr",  araddr,            ea);
    chk("ar_arid",    {60'd0, arid},     {63'd0, g});
    chk("ar_arlen",   {56'd0, arlen},    {56'd0, el});
    chk("ar_arsize",  {61'd0, arsize},   {61'd0, es});
    chk("ar_arburst", {62'd0, arburst},  64'd1);
    tick();
    arready = 1'b0;

    rr = 1'b1;
    for (int b = 0; b <= int'(el); b++) begin
      d   = (b == 0) ? d0 : {$urandom, $urandom};
      rs  = 2'($urandom_range(0, 3));
      lst = (b == int'(el));
      if ($urandom_range(0, 3) == 0) begin
        rvalid = 1'b0;
        if (g) m1_rready = 1'($urandom_range(0, 1)); else m0_rready = 1'($urandom_range(0, 1));
        #1;
        chk("gap_rvalid", {63'd0, (g ? m1_rvalid : m0_rvalid)}, 64'd0);
        chk("gap_rready", {63'd0, rready}, {63'd0, (g ? m1_rready : m0_rready)});
        chk("gap_arvalid", {63'd0, arvalid}, 64'd0);
        tick();
      end
      rvalid = 1'b1; rdata = d; rresp = rs; rlast = lst; rid = 4'($urandom);
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : !rr;
      if (g) begin m1_rready = rr; m0_rready = 1'($urandom_range(0, 1)); end
      else   begin m0_rready = rr; m1_rready = 1'($urandom_range(0, 1)); end
      #1;
      chk("beat_rready", {63'd0, rready}, {63'd0, rr});
      chk("beat_rvalid", {63'd0, (g ? m1_rvalid : m0_rvalid)}, 64'd1);
      chk("beat_rdata",  (g ? m1_rdata : m0_rdata), d);
      chk("beat_rresp",  {62'd0, (g ? m1_rresp : m0_rresp)}, {62'd0, rs});
      chk("beat_rlast",  {63'd0, (g ? m1_rlast : m0_rlast)}, {63'd0, lst});
      chk("other_rvalid", {63'd0, (g ? m0_rvalid : m1_rvalid)}, 64'd0);
      chk("other_rdata",  (g ? m0_rdata : m1_rdata), 64'd0);
      chk("other_rresp",  {62'd0, (g ? m0_rresp : m1_rresp)}, 64'd0);
      chk("other_rlast",  {63'd0, (g ? m0_rlast : m1_rlast)}, 64'd0);
      if (!rr) begin
        tick();
        rr = 1'b1;
        if (g) m1_rready = 1'b1; else m0_rready = 1'b1;
        #1;
        chk("stall_rready", {63'd0, rready}, 64'd1);
        chk("stall_rdata",  (g ? m1_rdata : m0_rdata), d);
      end
      tick();
    end
    rvalid = 1'b0; rlast = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
    #1;
    chk("done_rready",  {63'd0, rready},  64'd0);
    chk("done_arvalid", {63'd0, arvalid}, 64'd0);
    model_last = g;
  endtask

  initial begin
    bit r0, r1;
    arsetn = 1'b0;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    m0_araddr = '0; m1_araddr = '0; m0_arlen = '0; m1_arlen = '0;
    m0_arsize = '0; m1_arsize = '0; m0_rready = 1'b0; m1_rready = 1'b0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;

    // Reset with both masters requesting.
    #1;
    chk_quiet("rst0");
    tick();
    chk_quiet("rst1");
    tick();
    chk_quiet("rst2");
    arsetn = 1'b1;
    model_last = 1'b0;

    // First tie after reset goes to M1.
    run_txn(1, 1, 64'h1000, 64'h2000, 8'd0, 8'd0, 3'd3, 3'd3, 0, 0, 64'hA5A5_0000_0000_0001);

    // Single M0 read.
    run_txn(1, 0, 64'h8000_0000, 64'h0, 8'd0, 8'd0, 3'd3, 3'd0, 0, 0, 64'h1122_3344_5566_7788);

    // Continuous contention: alternating grants.
    for (int i = 0; i < 4; i++)
      run_txn(1, 1, 64'h3000 + 64'(i), 64'h4000 + 64'(i), 8'd0, 8'd0, 3'd2, 3'd3, 0, 0,
              {$urandom, $urandom});

    // M1 four-beat burst with toggling rready.
    run_txn(0, 1, 64'h0, 64'h8000_1000, 8'd0, 8'd3, 3'd0, 3'd3, 0, 2, {$urandom, $urandom});

    // Slave holds arready low for 5 cycles.
    run_txn(1, 0, 64'h8000_2000, 64'h0, 8'd1, 8'd0, 3'd3, 3'd0, 5, 0, {$urandom, $urandom});

    // Reset in the middle of an M1 burst.
    m1_arvalid = 1'b1; m1_araddr = 64'h8000_3000; m1_arlen = 8'd3; m1_arsize = 3'd3;
    tick();
    m1_arvalid = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    rvalid = 1'b1; rdata = 64'hDEAD_BEEF_0000_0000; rlast = 1'b0; m1_rready = 1'b1;
    #1;
    chk("mid_m1_rvalid", {63'd0, m1_rvalid}, 64'd1);
    tick();
    arsetn = 1'b0;
    m0_arvalid = 1'b1;
    #1;
    chk_quiet("midrst0");
    tick();
    chk_quiet("midrst1");
    arsetn = 1'b1;
    m0_arvalid = 1'b0;
    #1;
    chk("post_rst_m1_rvalid", {63'd0, m1_rvalid}, 64'd0);
    chk("post_rst_rready",    {63'd0, rready},    64'd0);
    chk("post_rst_arvalid",   {63'd0, arvalid},   64'd0);
    rvalid = 1'b0; m1_rready = 1'b0;
    model_last = 1'b0;
    run_txn(1, 0, 64'h8000_4000, 64'h0, 8'd2, 8'd0, 3'd3, 3'd0, 1, 1, {$urandom, $urandom});

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      run_txn(r0, r1, {$urandom, $urandom}, {$urandom, $urandom},
              8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
              3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
              {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22050710_axi4_rd_arbiter.md
YSYX_22050710_AXI4_RD_ARBITER -- requirements
Module: ysyx_22050710_axi4_rd_arbiter

Purpose: 2:1 AXI4-full read-channel arbiter. M0 = IFU, M1 = LSU. The single master-side port drives the SRAM AXI4 slave. One outstanding read at a time.

Interface
REQ-001 SHALL have parameter SRAM_ADDR_WD, default 64, read address width.
REQ-002 SHALL have parameter SRAM_DATA_WD, default 64, read data width.
REQ-003 SHALL have port i_aclk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_arsetn, input, 1 bit, reset; synchronous, active-low.
REQ-005 SHALL have port i_mN_arvalid, input, 1 bit, read request from master N (N = 0, 1).
REQ-006 SHALL have port o_mN_arready, output, 1 bit, request accepted for master N.
REQ-007 SHALL have port i_mN_araddr, input, SRAM_ADDR_WD bits, master N address.
REQ-008 SHALL have port i_mN_arlen, input, 8 bits, master N beats minus 1.
REQ-009 SHALL have port i_mN_arsize, input, 3 bits, master N beat size.
REQ-010 SHALL have port o_mN_rvalid, output, 1 bit, read beat valid to master N.
REQ-011 SHALL have port i_mN_rready, input, 1 bit, master N ready for a beat.
REQ-012 SHALL have port o_mN_rdata, output, SRAM_DATA_WD bits, beat data to master N.
REQ-013 SHALL have port o_mN_rresp, output, 2 bits, beat response to master N.
REQ-014 SHALL have port o_mN_rlast, output, 1 bit, last beat to master N.
REQ-015 SHALL have port o_arid, output, 4 bits, equal to {3'b0, grant}.
REQ-016 SHALL have ports o_araddr (SRAM_ADDR_WD), o_arlen (8), o_arsize (3) and o_arvalid (1) as outputs, plus i_arready (1) as input: the slave AR channel.
REQ-017 SHALL have port o_arburst, output, 2 bits, constant 2'b01 (INCR).
REQ-018 SHALL have ports i_rid (4), i_rdata (SRAM_DATA_WD), i_rresp (2), i_rlast (1) and i_rvalid (1) as inputs, plus o_rready (1) as output: the slave R channel.

Function
REQ-019 SHALL implement a three-state FSM: IDLE, ADDR, DATA.
REQ-020 In IDLE, if exactly one i_mN_arvalid is high, that master SHALL be granted.
REQ-021 In IDLE, if both are high, the master not granted last SHALL be granted (round-robin via register last_grant).
REQ-022 In the IDLE grant cycle, o_mN_arready SHALL be 1 combinationally for the granted master only.
REQ-023 In the IDLE grant cycle, the arbiter SHALL register grant, araddr, arlen and arsize, then enter ADDR on the next edge.
REQ-024 o_mN_arready SHALL be 0 in ADDR and DATA.
REQ-025 In ADDR, o_arvalid SHALL be 1 with the registered fields held stable until i_arready; on i_arready the FSM SHALL go to DATA.
REQ-026 o_arvalid SHALL be 0 outside ADDR.
REQ-027 In DATA, o_rready SHALL equal i_grant_rready, and i_rvalid/i_rdata/i_rresp/i_rlast SHALL route to the granted master's o_mN_r* outputs.
REQ-028 The non-granted master SHALL see rvalid = 0, rdata = 0, rresp = 0 and rlast = 0.
REQ-029 In DATA, i_rvalid && o_rready && i_rlast SHALL return the FSM to IDLE and set last_grant = grant.
REQ-030 Routing SHALL use the grant register only; i_rid SHALL be ignored.
REQ-031 In IDLE and ADDR, o_rready SHALL be 0 and all o_mN_rvalid SHALL be 0; i_rvalid SHALL be ignored.
REQ-032 Latency: request accepted at cycle T, o_arvalid at T+1.
REQ-033 After the rlast beat, the next request SHALL be grantable on the following cycle (one bubble).
REQ-034 A burst of arlen+1 beats SHALL be delivered in order; beat stalls SHALL follow master rready.

Reset
REQ-035 While i_arsetn = 0 at a clock edge, the arbiter SHALL force state = IDLE, last_grant = 0, and all registered fields = 0.
REQ-036 During reset, o_arvalid, o_rready, o_mN_arready and o_mN_rvalid SHALL all be 0.
REQ-037 Reset asserted in ADDR or DATA SHALL abandon the transaction; no further beats SHALL be routed.
REQ-038 Because last_grant = 0 after reset, the first tie SHALL go to M1.

Verification
REQ-039 Reset: i_arsetn = 0 for 2 cycles with both arvalid = 1 -> all handshake outputs 0; on release, the first grant goes to M1 (o_arid = 1).
REQ-040 Single M0 read: araddr 0x80000000, len 0, i_arready = 1 -> o_m0_arready at T; o_arvalid/o_araddr = 0x80000000/o_arid = 0 at T+1; rdata 0x1122334455667788 with rlast -> o_m0_rvalid = 1 with that data, o_m1_rvalid = 0.
REQ-041 Both masters requesting continuously, len 0 -> grants alternate M1, M0, M1, M0.
REQ-042 M1 burst, len 3, with i_m1_rready toggling -> 4 beats delivered in order, o_rready mirrors i_m1_rready, IDLE only after the 4th (rlast) beat.
REQ-043 i_arready held 0 for 5 cycles -> o_arvalid = 1 and o_araddr constant throughout; no o_mN_arready asserted.
REQ-044 Reset asserted mid-burst in DATA -> IDLE next edge, outputs at reset values; a subsequent M0 request completes normally.
